cache_rand_victim: RTL and testbench

CACHE_RAND_VICTIM -- requirements
Module: cache_rand_victim

---
 rtl/cache_rand_victim_if.sv | 31 +++
 rtl/cache_rand_victim.sv | 142 ++++++++++++++
 tb/tb_cache_rand_victim.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cache_rand_victim_if.sv
// rtl/cache_rand_victim_if.sv - allocation request / victim offer bundle for cache_rand_victim
interface cache_rand_victim_if #(
    parameter int NUMWAYS   = 4,
    parameter int LFSRWIDTH = 4
);
    logic                 AllocReq;
    logic [NUMWAYS-1:0]   ValidWay;
    logic [NUMWAYS-1:0]   LockedWay;
    logic [LFSRWIDTH-1:0] LfsrData;
    logic                 VictimAck;
    logic                 LfsrLoad;
    logic [LFSRWIDTH-1:0] LfsrSeed;
    logic                 LfsrEnable;
    logic                 VictimValid;
    logic [NUMWAYS-1:0]   VictimWay;
    logic                 VictimNone;
    logic [15:0]          RandEvictCnt;
    logic [15:0]          InvFillCnt;

    modport master (
        output AllocReq, ValidWay, LockedWay, LfsrData, VictimAck,
        input  LfsrLoad, LfsrSeed, LfsrEnable, VictimValid, VictimWay, VictimNone,
               RandEvictCnt, InvFillCnt
    );

    modport slave (
        input  AllocReq, ValidWay, LockedWay, LfsrData, VictimAck,
        output LfsrLoad, LfsrSeed, LfsrEnable, VictimValid, VictimWay, VictimNone,
               RandEvictCnt, InvFillCnt
    );
endinterface

// File: rtl/cache_rand_victim.sv
// rtl/cache_rand_victim.sv - random victim way selector driving an external LFSR
// Optional statistics counters enabled by macro RAND_VICTIM_STATS_EN.
module cache_rand_victim #(
    parameter int NUMWAYS   = 4,
    parameter int LFSRWIDTH = 4,
    parameter int SEED      = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cache_rand_victim_if.slave   bus
);
    localparam int IDXW = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;
    localparam int MODW = LFSRWIDTH + 1;

    typedef enum logic [1:0] {ST_SEED, ST_IDLE, ST_OFFER} state_t;

    state_t             state;
    logic               load_q;
    logic               enable_q;
    logic               valid_q;
    logic [NUMWAYS-1:0] way_q;
    logic               none_q;
    logic               used_rand;
    logic               used_inv;

    logic [NUMWAYS-1:0] free;
    logic [NUMWAYS-1:0] sel_way;
    logic               sel_none;
    logic               sel_rand;
    logic               sel_inv;
    logic [IDXW-1:0]    start;
    logic [IDXW-1:0]    idx;
    logic               found;
    logic               ack_fire;

    // Priority: invalid+unlocked lowest index, else LFSR-seeded scan over unlocked ways.
    always_comb begin
        sel_way  = '0;
        sel_none = 1'b0;
        sel_rand = 1'b0;
        sel_inv  = 1'b0;
        idx      = '0;
        found    = 1'b0;
        free     = ~bus.ValidWay & ~bus.LockedWay;
        start    = IDXW'({1'b0, bus.LfsrData} % MODW'(NUMWAYS));
        if (|free) begin
            sel_inv = 1'b1;
            for (int i = NUMWAYS - 1; i >= 0; i--) begin
                if (free[i]) sel_way = NUMWAYS'(1) << i;
            end
        end else if (!(&bus.LockedWay)) begin
            sel_rand = 1'b1;
            for (int i = 0; i < NUMWAYS; i++) begin
                idx = start + IDXW'(i);
                if (!found && !bus.LockedWay[idx]) begin
                    found   = 1'b1;
                    sel_way = NUMWAYS'(1) << idx;
                end
            end
        end else begin
            sel_none = 1'b1;
        end
    end

    assign ack_fire = (state == ST_OFFER) && bus.VictimAck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_SEED;
            load_q    <= 1'b0;
            enable_q  <= 1'b0;
            valid_q   <= 1'b0;
            way_q     <= '0;
            none_q    <= 1'b0;
            used_rand <= 1'b0;
            used_inv  <= 1'b0;
        end else begin
            enable_q <= 1'b0;
            case (state)
                // First edge raises the load; the second drops it and leaves SEED.
                ST_SEED: begin
                    if (!load_q) begin
                        load_q <= 1'b1;
                    end else begin
                        load_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.AllocReq) begin
                        valid_q   <= 1'b1;
                        way_q     <= sel_way;
                        none_q    <= sel_none;
                        used_rand <= sel_rand;
                        used_inv  <= sel_inv;
                        state     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (bus.VictimAck) begin
                        valid_q  <= 1'b0;
                        way_q    <= '0;
                        none_q   <= 1'b0;
                        enable_q <= used_rand;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_SEED;
            endcase
        end
    end

    assign bus.LfsrLoad    = load_q;
    assign bus.LfsrSeed    = LFSRWIDTH'(SEED);
    assign bus.LfsrEnable  = enable_q;
    assign bus.VictimValid = valid_q;
    assign bus.VictimWay   = way_q;
    assign bus.VictimNone  = none_q;

`ifdef RAND_VICTIM_STATS_EN
    logic [15:0] rand_cnt;
    logic [15:0] inv_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rand_cnt <= '0;
            inv_cnt  <= '0;
        end else if (ack_fire) begin
            if (used_rand && rand_cnt != 16'hFFFF) rand_cnt <= rand_cnt + 16'd1;
            if (used_inv && inv_cnt != 16'hFFFF)   inv_cnt  <= inv_cnt + 16'd1;
        end
    end

    assign bus.RandEvictCnt = rand_cnt;
    assign bus.InvFillCnt   = inv_cnt;
`else
    logic unused_ack;
    assign unused_ack       = ack_fire;
    assign bus.RandEvictCnt = '0;
    assign bus.InvFillCnt   = '0;
`endif
endmodule

// File: tb/tb_cache_rand_victim.sv
// tb/tb_cache_rand_victim.sv - scoreboard bench for cache_rand_victim (NUMWAYS=4, LFSRWIDTH=4, SEED=1)
module tb_cache_rand_victim;
    logic clk;
    logic reset_n;

    cache_rand_victim_if #(.NUMWAYS(4), .LFSRWIDTH(4)) bus ();

    cache_rand_victim #(.NUMWAYS(4), .LFSRWIDTH(4), .SEED(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [4:0] exp_q[$];
    logic       prev_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef RAND_VICTIM_STATS_EN
        return 32'(n);
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Pops one expected decision each time an offer starts.
    always @(negedge clk) begin
        logic [4:0] e;
        if (reset_n && bus.VictimValid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sb_unexpected_offer: got way 0x%0h expected no offer", bus.VictimWay);
            end else begin
                e = exp_q.pop_front();
                check("sb_way", 32'(bus.VictimWay), 32'(e[3:0]));
                check("sb_none", 32'(bus.VictimNone), 32'(e[4]));
                check("sb_onehot", 32'($countones(bus.VictimWay) <= 1), 32'd1);
            end
        end
        prev_valid = reset_n && bus.VictimValid;
    end

    task automatic do_alloc(input string nm, input logic [3:0] valid, input logic [3:0] locked,
                            input logic [3:0] lfsr, input logic [3:0] exp_way, input logic exp_none);
        bus.ValidWay  = valid;
        bus.LockedWay = locked;
        bus.LfsrData  = lfsr;
        bus.AllocReq  = 1'b1;
        exp_q.push_back({exp_none, exp_way});
        @(negedge clk);
        bus.AllocReq = 1'b0;
        check({nm, "_latency"}, 32'(bus.VictimValid), 32'd1);
    endtask

    task automatic do_ack(input string nm, input logic exp_en, input int exp_rand, input int exp_inv);
        bus.VictimAck = 1'b1;
        @(negedge clk);
        bus.VictimAck = 1'b0;
        check({nm, "_valid_drop"}, 32'(bus.VictimValid), 32'd0);
        check({nm, "_lfsr_en"}, 32'(bus.LfsrEnable), 32'(exp_en));
        check({nm, "_rand_cnt"}, 32'(bus.RandEvictCnt), cnt_exp(exp_rand));
        check({nm, "_inv_cnt"}, 32'(bus.InvFillCnt), cnt_exp(exp_inv));
        @(negedge clk);
        check({nm, "_lfsr_en_off"}, 32'(bus.LfsrEnable), 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.AllocReq  = 1'b0;
        bus.ValidWay  = '0;
        bus.LockedWay = '0;
        bus.LfsrData  = '0;
        bus.VictimAck = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.VictimValid), 32'd0);
        check("rst_way", 32'(bus.VictimWay), 32'd0);
        check("rst_none", 32'(bus.VictimNone), 32'd0);
        check("rst_load", 32'(bus.LfsrLoad), 32'd0);
        check("rst_enable", 32'(bus.LfsrEnable), 32'd0);
        check("rst_cnts", 32'({bus.RandEvictCnt, bus.InvFillCnt}), 32'd0);

        // Seeding: load high for exactly the first cycle after release.
        reset_n = 1'b1;
        @(negedge clk);
        check("seed_load", 32'(bus.LfsrLoad), 32'd1);
        check("seed_value", 32'(bus.LfsrSeed), 32'd1);
        check("seed_valid", 32'(bus.VictimValid), 32'd0);
        @(negedge clk);
        check("seed_load_off", 32'(bus.LfsrLoad), 32'd0);

        // Rule 1: way 2 is the only invalid one.
        do_alloc("inv_fill", 4'b1011, 4'b0000, 4'b0000, 4'b0100, 1'b0);
        do_ack("inv_fill", 1'b0, 0, 1);

        // Rule 2: start at 2 (locked), next is 3.
        do_alloc("rand_skip", 4'b1111, 4'b0100, 4'b1010, 4'b1000, 1'b0);
        do_ack("rand_skip", 1'b1, 1, 1);

        // Rule 2 wrap: start at 3 (locked), wraps to 0; offer held while inputs churn.
        do_alloc("wrap", 4'b1111, 4'b1000, 4'b0011, 4'b0001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.ValidWay  = 4'(i);
            bus.LockedWay = 4'(5 - i);
            bus.LfsrData  = 4'(i + 7);
            bus.AllocReq  = 1'b1;
            @(negedge clk);
            check("hold_way", 32'(bus.VictimWay), 32'b0001);
            check("hold_valid", 32'(bus.VictimValid), 32'd1);
        end
        bus.AllocReq = 1'b0;
        do_ack("wrap", 1'b1, 2, 1);
        check("no_queued_alloc", 32'(bus.VictimValid), 32'd0);

        // Rule 3: everything locked.
        do_alloc("all_locked", 4'b1111, 4'b1111, 4'b0101, 4'b0000, 1'b1);
        do_ack("all_locked", 1'b0, 2, 1);

        // Invalid but locked way 0 is skipped in favour of way 1.
        do_alloc("inv_locked", 4'b0000, 4'b0001, 4'b0000, 4'b0010, 1'b0);
        do_ack("inv_locked", 1'b0, 2, 2);

        // Rule 2 from index 0 with nothing locked; upper LFSR bits ignored.
        do_alloc("rand_zero", 4'b1111, 4'b0000, 4'b0100, 4'b0001, 1'b0);
        do_ack("rand_zero", 1'b1, 3, 2);

        // Ack while idle does nothing.
        bus.VictimAck = 1'b1;
        @(negedge clk);
        bus.VictimAck = 1'b0;
        check("idle_ack_valid", 32'(bus.VictimValid), 32'd0);
        check("idle_ack_enable", 32'(bus.LfsrEnable), 32'd0);

        // Reset mid-offer drops the offer asynchronously.
        do_alloc("rst_offer", 4'b1111, 4'b0000, 4'b0010, 4'b0100, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("async_drop_valid", 32'(bus.VictimValid), 32'd0);
        check("async_drop_way", 32'(bus.VictimWay), 32'd0);
        @(negedge clk);
        check("rst2_cnts", 32'({bus.RandEvictCnt, bus.InvFillCnt}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("reseed_load", 32'(bus.LfsrLoad), 32'd1);
        check("reseed_valid", 32'(bus.VictimValid), 32'd0);
        @(negedge clk);
        check("reseed_load_off", 32'(bus.LfsrLoad), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
